pt5_stream_unpacker: RTL and testbench

- Converts a byte stream of PT-5 packed ternary data (5 trits per byte) into LANES-wide vectors of 2-bit trits for vector_engine.
- One instance feeds bus_weights and another feeds bus_inputs. vector_engine enable is driven externally from the joined m_valid & m_ready of both instances.
- Handles backpressure, end-of-stream flush with zero padding, and invalid-byte detection.

---
 rtl/pt5_pkg.sv | 18 +
 rtl/pt5_byte_decode.sv | 32 +++
 rtl/pt5_stream_unpacker.sv | 156 +++++++++++++++
 tb/tb_pt5_stream_unpacker.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pt5_pkg.sv
// Shared trit encodings and constants for the PT-5 unpacker slice.
package pt5_pkg;

    typedef logic [1:0] trit_t;

    localparam trit_t TRIT_ZERO = 2'b00;
    localparam trit_t TRIT_POS  = 2'b01;
    localparam trit_t TRIT_NEG  = 2'b10;

    localparam int unsigned PT5_TRITS     = 5;
    localparam int unsigned PT5_MAX_VALID = 242;

    typedef enum logic {
        ST_RUN,
        ST_FLUSH
    } state_t;

endpackage

// File: rtl/pt5_byte_decode.sv
// Combinational PT-5 byte decoder: five base-3 digits, earliest trit in bits [1:0].
module pt5_byte_decode
    import pt5_pkg::*;
(
    input  logic [7:0] data,
    output logic [9:0] trits,
    output logic       invalid
);

    assign invalid = data > 8'(PT5_MAX_VALID);

    always_comb begin
        logic [7:0] v;
        logic [7:0] d;
        v     = data;
        d     = '0;
        trits = '0;
        for (int unsigned k = 0; k < PT5_TRITS; k++) begin
            d = v % 8'd3;
            v = v / 8'd3;
            case (d)
                8'd0:    trits[k*2 +: 2] = TRIT_NEG;
                8'd1:    trits[k*2 +: 2] = TRIT_ZERO;
                default: trits[k*2 +: 2] = TRIT_POS;
            endcase
        end
        if (invalid) begin
            trits = '0;
        end
    end

endmodule

// File: rtl/pt5_stream_unpacker.sv
// PT-5 byte stream to LANES-wide trit vectors with flush and invalid-byte flag.
// Optional statistics ports are enabled by defining PT5_UNPACK_STATS_EN.
module pt5_stream_unpacker
    import pt5_pkg::*;
#(
    parameter int unsigned LANES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         s_data,
    input  logic               s_valid,
    input  logic               s_last,
    output logic               s_ready,
    output logic [LANES*2-1:0] m_trits,
    output logic               m_valid,
    output logic               m_last,
    input  logic               m_ready,
    output logic               err_invalid
`ifdef PT5_UNPACK_STATS_EN
    ,
    output logic [31:0]        stat_vectors,
    output logic [15:0]        stat_bad_bytes
`endif
);

    localparam int unsigned BUF_TRITS = LANES + 10;
    localparam int unsigned CW        = $clog2(BUF_TRITS + 1);

    typedef logic [CW-1:0] cnt_t;

    state_t     state;
    state_t     state_next;
    trit_t      tbuf      [BUF_TRITS];
    trit_t      tbuf_next [BUF_TRITS];
    cnt_t       count;
    cnt_t       count_next;
    cnt_t       pop_amt;
    cnt_t       surv;
    logic [9:0] dec_trits;
    logic       dec_invalid;
    logic       push;
    logic       pop;
    logic       pop_last;

    pt5_byte_decode u_decode (
        .data    (s_data),
        .trits   (dec_trits),
        .invalid (dec_invalid)
    );

    assign push     = s_valid & s_ready;
    assign pop      = m_valid & m_ready;
    assign pop_last = pop & m_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:   if (push && s_last) state_next = ST_FLUSH;
            ST_FLUSH: if (pop_last)       state_next = ST_RUN;
            default:  state_next = ST_RUN;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_last  = 1'b0;
        case (state)
            ST_RUN: begin
                s_ready = count <= cnt_t'(BUF_TRITS - PT5_TRITS);
                m_valid = count >= cnt_t'(LANES);
            end
            ST_FLUSH: begin
                m_valid = count != '0;
                m_last  = count <= cnt_t'(LANES);
            end
            default: ;
        endcase
    end

    assign pop_amt    = !pop ? '0 : (count < cnt_t'(LANES)) ? count : cnt_t'(LANES);
    assign surv       = count - pop_amt;
    assign count_next = surv + (push ? cnt_t'(PT5_TRITS) : '0);

    // Entries at or beyond the new count are cleared, so lanes past the
    // buffered data read as zero without a separate output mask.
    always_comb begin
        for (int unsigned i = 0; i < BUF_TRITS; i++) begin
            tbuf_next[i] = TRIT_ZERO;
            if (32'(i) < 32'(surv)) begin
                if (i + 32'(pop_amt) < BUF_TRITS) begin
                    tbuf_next[i] = tbuf[i + 32'(pop_amt)];
                end
            end else if (push) begin
                for (int unsigned k = 0; k < PT5_TRITS; k++) begin
                    if (i == 32'(surv) + k) begin
                        tbuf_next[i] = dec_trits[k*2 +: 2];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
            for (int unsigned i = 0; i < BUF_TRITS; i++) begin
                tbuf[i] <= TRIT_ZERO;
            end
        end else begin
            count <= count_next;
            for (int unsigned i = 0; i < BUF_TRITS; i++) begin
                tbuf[i] <= tbuf_next[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            m_trits[i*2 +: 2] = tbuf[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_invalid <= 1'b0;
        end else if (push && dec_invalid) begin
            err_invalid <= 1'b1;
        end
    end

`ifdef PT5_UNPACK_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_vectors   <= '0;
            stat_bad_bytes <= '0;
        end else begin
            if (pop) begin
                stat_vectors <= stat_vectors + 32'd1;
            end
            if (push && dec_invalid && stat_bad_bytes != '1) begin
                stat_bad_bytes <= stat_bad_bytes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pt5_stream_unpacker.sv
// Scoreboard bench for pt5_stream_unpacker (LANES=16).
module tb_pt5_stream_unpacker;

    localparam int unsigned LANES     = 16;
    localparam int unsigned BUF_TRITS = LANES + 10;

    logic               clk     = 1'b0;
    logic               reset   = 1'b0;
    logic [7:0]         s_data  = '0;
    logic               s_valid = 1'b0;
    logic               s_last  = 1'b0;
    logic               s_ready;
    logic [LANES*2-1:0] m_trits;
    logic               m_valid;
    logic               m_last;
    logic               m_ready = 1'b0;
    logic               err_invalid;
`ifdef PT5_UNPACK_STATS_EN
    logic [31:0]        stat_vectors;
    logic [15:0]        stat_bad_bytes;
`endif

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q [$];
    logic       mdl_flush = 1'b0;

    always #5 clk = ~clk;

    pt5_stream_unpacker #(.LANES(LANES)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_last      (s_last),
        .s_ready     (s_ready),
        .m_trits     (m_trits),
        .m_valid     (m_valid),
        .m_last      (m_last),
        .m_ready     (m_ready),
        .err_invalid (err_invalid)
`ifdef PT5_UNPACK_STATS_EN
        ,
        .stat_vectors   (stat_vectors),
        .stat_bad_bytes (stat_bad_bytes)
`endif
    );

    function automatic logic [9:0] model_decode(input int unsigned b);
        logic [9:0]  t;
        int unsigned v;
        t = '0;
        v = b;
        if (b > 242) return '0;
        for (int k = 0; k < 5; k++) begin
            case (v % 3)
                0:       t[k*2 +: 2] = 2'b10;
                1:       t[k*2 +: 2] = 2'b00;
                default: t[k*2 +: 2] = 2'b01;
            endcase
            v = v / 3;
        end
        return t;
    endfunction

    // Inputs change #1 after posedge, so the negedge view is what the next edge sees.
    always @(negedge clk) begin
        int unsigned        n;
        logic [LANES*2-1:0] ev;
        logic               el;
        logic               emv;
        logic               esr;
        logic [9:0]         dt;
        if (!reset) begin
            exp_q.delete();
            mdl_flush = 1'b0;
        end else begin
            emv = mdl_flush ? (exp_q.size() > 0) : (exp_q.size() >= LANES);
            esr = !mdl_flush && (exp_q.size() <= BUF_TRITS - 5);
            el  = mdl_flush && (exp_q.size() <= LANES);
            checks++;
            if (m_valid !== emv || s_ready !== esr || m_last !== el) begin
                errors++;
                $display("FAIL flags t=%0t: m_valid=%b s_ready=%b m_last=%b required %b %b %b",
                         $time, m_valid, s_ready, m_last, emv, esr, el);
            end
            if (m_valid && m_ready) begin
                n  = (exp_q.size() < LANES) ? exp_q.size() : LANES;
                ev = '0;
                for (int unsigned i = 0; i < n; i++) ev[i*2 +: 2] = exp_q.pop_front();
                checks++;
                if (m_trits !== ev) begin
                    errors++;
                    $display("FAIL beat t=%0t: m_trits=%h required %h", $time, m_trits, ev);
                end
                if (el) mdl_flush = 1'b0;
            end
            if (s_valid && s_ready) begin
                dt = model_decode(int'(s_data));
                for (int k = 0; k < 5; k++) exp_q.push_back(dt[k*2 +: 2]);
                if (s_last) mdl_flush = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        int unsigned t;
        t       = 0;
        s_data  = d;
        s_valid = 1'b1;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && t < 200) begin
            t++;
            @(negedge clk);
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%b required 1", s_ready);
        end
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int unsigned t;
        t = 0;
        while ((exp_q.size() != 0 || mdl_flush) && t < 500) begin
            tick();
            t++;
        end
        checks++;
        if (exp_q.size() != 0 || mdl_flush) begin
            errors++;
            $display("FAIL drain_timeout: %0d trits left, flush=%b, required 0 and 0",
                     exp_q.size(), mdl_flush);
        end
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        checks += 5;
        if (s_ready !== 1'b1)   begin errors++; $display("FAIL reset_s_ready: %b required 1", s_ready); end
        if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_m_valid: %b required 0", m_valid); end
        if (m_last !== 1'b0)    begin errors++; $display("FAIL reset_m_last: %b required 0", m_last); end
        if (m_trits !== '0)     begin errors++; $display("FAIL reset_m_trits: %h required 0", m_trits); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL reset_err: %b required 0", err_invalid); end
        tick();
        reset = 1'b1;
    endtask

    task automatic test_full_vector();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(8'd242, 1'b0);
        @(negedge clk);
        checks += 3;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL full_latency: m_valid=%b required 1", m_valid); end
        if (m_trits !== 32'h5555_5555) begin errors++; $display("FAIL full_trits: %h required 55555555", m_trits); end
        if (m_last !== 1'b0) begin errors++; $display("FAIL full_last: %b required 0", m_last); end
        tick();
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin errors++; $display("FAIL full_remainder: m_valid=%b required 0", m_valid); end
        tick();
        send(8'd242, 1'b1);
        wait_idle();
    endtask

    task automatic test_flush_single();
        send(8'd0, 1'b1);
        @(negedge clk);
        checks += 3;
        if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid: %b required 1", m_valid); end
        if (m_trits !== 32'h0000_02AA) begin errors++; $display("FAIL single_trits: %h required 000002aa", m_trits); end
        if (m_last !== 1'b1) begin errors++; $display("FAIL single_last: %b required 1", m_last); end
        tick();
        @(negedge clk);
        checks += 2;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL single_back_run: s_ready=%b required 1", s_ready); end
        if (m_valid !== 1'b0) begin errors++; $display("FAIL single_after: m_valid=%b required 0", m_valid); end
        tick();
    endtask

    task automatic test_mixed();
        logic [31:0] ev;
        ev = '0;
        ev[1:0] = 2'b01;
        ev[3:2] = 2'b00;
        ev[5:4] = 2'b10;
        ev[7:6] = 2'b10;
        ev[9:8] = 2'b10;
        send(8'd5, 1'b0);
        send(8'd121, 1'b1);
        @(negedge clk);
        checks += 2;
        if (m_trits !== ev) begin errors++; $display("FAIL mixed_trits: %h required %h", m_trits, ev); end
        if (m_last !== 1'b1) begin errors++; $display("FAIL mixed_last: %b required 1", m_last); end
        wait_idle();
    endtask

    task automatic test_invalid();
        checks++;
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL invalid_pre: %b required 0", err_invalid); end
        send(8'd250, 1'b0);
        @(negedge clk);
        checks++;
        if (err_invalid !== 1'b1) begin errors++; $display("FAIL invalid_flag: %b required 1", err_invalid); end
`ifdef PT5_UNPACK_STATS_EN
        checks++;
        if (stat_bad_bytes !== 16'd1) begin errors++; $display("FAIL invalid_stat: %0d required 1", stat_bad_bytes); end
`endif
        tick();
        for (int i = 0; i < 3; i++) send(8'd242, 1'b0);
        @(negedge clk);
        checks++;
        if (m_trits[9:0] !== 10'd0) begin errors++; $display("FAIL invalid_zero_trits: %h required 000", m_trits[9:0]); end
        tick();
        send(8'd242, 1'b1);
        wait_idle();
        checks++;
        if (err_invalid !== 1'b1) begin errors++; $display("FAIL invalid_sticky: %b required 1", err_invalid); end
    endtask

    task automatic test_backpressure();
        logic [LANES*2-1:0] hold;
        logic               hold_last;
        logic [7:0]         pend;
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(8'($urandom_range(0, 242)), 1'b0);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: %b required 0", s_ready); end
        hold      = m_trits;
        hold_last = m_last;
        pend      = 8'($urandom_range(0, 242));
        tick();
        s_data  = pend;
        s_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (m_trits !== hold || m_last !== hold_last || s_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stable: m_trits=%h m_last=%b s_ready=%b required %h %b 0",
                         m_trits, m_last, s_ready, hold, hold_last);
            end
        end
        tick();
        m_ready = 1'b1;
        send(pend, 1'b0);
        for (int i = 0; i < 6; i++) send(8'($urandom_range(0, 242)), i == 5);
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int lows;
        lows    = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_data  = 8'($urandom_range(0, 255));
            s_valid = 1'b1;
            s_last  = (i == 23);
            @(negedge clk);
            if (!s_ready) lows++;
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        checks++;
        if (lows != 0) begin errors++; $display("FAIL b2b_s_ready: %0d stalls required 0", lows); end
        wait_idle();
    endtask

    task automatic test_reset_flush();
        logic [31:0] ev;
        m_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            s_data  = 8'($urandom_range(0, 242));
            s_valid = 1'b1;
            s_last  = (i == 10);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        checks += 4;
        if (exp_q.size() != 7) begin errors++; $display("FAIL rf_count: %0d required 7", exp_q.size()); end
        if (m_valid !== 1'b1 || m_last !== 1'b1) begin
            errors++; $display("FAIL rf_flags: m_valid=%b m_last=%b required 1 1", m_valid, m_last);
        end
        if (m_trits[31:14] !== '0) begin errors++; $display("FAIL rf_pad: %h required 0", m_trits[31:14]); end
        if (s_ready !== 1'b0) begin errors++; $display("FAIL rf_s_ready: %b required 0", s_ready); end
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        @(negedge clk);
        checks += 5;
        if (s_ready !== 1'b1)     begin errors++; $display("FAIL rf_reset_s_ready: %b required 1", s_ready); end
        if (m_valid !== 1'b0)     begin errors++; $display("FAIL rf_reset_m_valid: %b required 0", m_valid); end
        if (m_last !== 1'b0)      begin errors++; $display("FAIL rf_reset_m_last: %b required 0", m_last); end
        if (m_trits !== '0)       begin errors++; $display("FAIL rf_reset_m_trits: %h required 0", m_trits); end
        if (err_invalid !== 1'b0) begin errors++; $display("FAIL rf_reset_err: %b required 0", err_invalid); end
        tick();
        m_ready = 1'b1;
        ev = 32'h0000_02A1;
        send(8'd5, 1'b1);
        @(negedge clk);
        checks++;
        if (m_trits !== ev || m_last !== 1'b1) begin
            errors++; $display("FAIL rf_restart: m_trits=%h m_last=%b required %h 1", m_trits, m_last, ev);
        end
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_full_vector();
        test_flush_single();
        test_mixed();
        test_invalid();
        test_backpressure();
        test_back_to_back();
        test_reset_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
